// File: rtl/operand_fetch.sv
// operand_fetch: single-entry operand fetch stage with register file read, writeback bypass
// and pending-write scoreboard between decode and execute.
module operand_fetch #(
   parameter int XLEN      = 32,
   parameter int RADDR_W   = 5,
   parameter int PAYLOAD_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [RADDR_W-1:0]   in_rs1,
   input  logic [RADDR_W-1:0]   in_rs2,
   input  logic [RADDR_W-1:0]   in_rd,
   input  logic                 in_wen,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 flush,
   output logic [RADDR_W-1:0]   rf_rs1,
   output logic [RADDR_W-1:0]   rf_rs2,
   input  logic [XLEN-1:0]      rf_data1,
   input  logic [XLEN-1:0]      rf_data2,
   input  logic [RADDR_W-1:0]   wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_rs1_data,
   output logic [XLEN-1:0]      out_rs2_data,
   output logic [RADDR_W-1:0]   out_rd,
   output logic                 out_wen,
   output logic [PAYLOAD_W-1:0] out_payload
);
   localparam int NREG = 1 << RADDR_W;
   logic                 r_hv;
   logic [RADDR_W-1:0]   r_rs1;
   logic [RADDR_W-1:0]   r_rs2;
   logic [RADDR_W-1:0]   r_rd;
   logic                 r_wen;
   logic [PAYLOAD_W-1:0] r_payload;
   logic [NREG-1:0]      r_pend;
   logic                 r_byp1;
   logic                 r_byp2;
   logic [XLEN-1:0]      r_bdat1;
   logic [XLEN-1:0]      r_bdat2;
   logic                 w_acc;
   logic                 w_fire;
   logic                 w_hazard;
   logic                 w_wb;
   logic [NREG-1:0]      w_clr;
   logic [NREG-1:0]      w_set;

   assign w_hazard     = r_pend[r_rs1] | r_pend[r_rs2];
   assign out_valid    = r_hv & ~w_hazard;
   assign w_fire       = out_valid & out_ready;
   assign in_ready     = ~flush & (~r_hv | w_fire);
   assign w_acc        = in_valid & in_ready;
   assign rf_rs1       = w_acc ? in_rs1 : r_rs1;
   assign rf_rs2       = w_acc ? in_rs2 : r_rs2;
   assign w_wb         = wb_rd != '0;
   assign w_clr        = w_wb ? (NREG'(1) << wb_rd) : '0;
   assign w_set        = (w_fire & r_wen & (r_rd != '0)) ? (NREG'(1) << r_rd) : '0;
   assign out_rs1_data = (r_rs1 == '0) ? '0 : (r_byp1 ? r_bdat1 : rf_data1);
   assign out_rs2_data = (r_rs2 == '0) ? '0 : (r_byp2 ? r_bdat2 : rf_data2);
   assign out_rd       = r_rd;
   assign out_wen      = r_wen;
   assign out_payload  = r_payload;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hv      <= 1'b0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_wen     <= 1'b0;
         r_payload <= '0;
      end else if (flush) begin
         r_hv <= 1'b0;
      end else if (w_acc) begin
         r_hv      <= 1'b1;
         r_rs1     <= in_rs1;
         r_rs2     <= in_rs2;
         r_rd      <= in_rd;
         r_wen     <= in_wen;
         r_payload <= in_payload;
      end else if (w_fire) begin
         r_hv <= 1'b0;
      end
   end

   // The register file returns pre-write data on a same-edge read/write, so capture the write here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend  <= '0;
         r_byp1  <= 1'b0;
         r_byp2  <= 1'b0;
         r_bdat1 <= '0;
         r_bdat2 <= '0;
      end else begin
         r_pend  <= ((r_pend & ~w_clr) | w_set) & ~NREG'(1);
         r_byp1  <= w_wb & (wb_rd == rf_rs1);
         r_byp2  <= w_wb & (wb_rd == rf_rs2);
         r_bdat1 <= wb_data;
         r_bdat2 <= wb_data;
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed stimulus against a register file model and an architectural model
// of the stage; operands must always equal the current register contents.
module tb_operand_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [4:0]  in_rd = '0;
   logic        in_wen = 1'b0;
   logic [31:0] in_payload = '0;
   logic        flush = 1'b0;
   logic [4:0]  rf_rs1;
   logic [4:0]  rf_rs2;
   logic [31:0] rf_data1 = '0;
   logic [31:0] rf_data2 = '0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic [31:0] out_payload;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   logic [31:0] rf_mem [32] = '{default: 32'h0};
   logic        m_hv = 1'b0;
   logic [4:0]  m_rs1 = '0;
   logic [4:0]  m_rs2 = '0;
   logic [4:0]  m_rd = '0;
   logic        m_wen = 1'b0;
   logic [31:0] m_pay = '0;
   logic [31:0] m_pend = '0;
   logic [31:0] log_pay [$];
   int          log_cyc [$];

   operand_fetch dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
      .in_payload(in_payload), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_wen(out_wen),
      .out_payload(out_payload)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file: registered read of the pre-write value, x0 never written.
   always @(posedge clk) begin
      rf_data1 <= rf_mem[rf_rs1];
      rf_data2 <= rf_mem[rf_rs2];
      if (wb_rd != 0) rf_mem[wb_rd] <= wb_data;
   end

   function automatic logic f_valid();
      return m_hv && !m_pend[m_rs1] && !m_pend[m_rs2];
   endfunction

   function automatic logic f_ready();
      return !flush && (!m_hv || (f_valid() && out_ready));
   endfunction

   function automatic logic [31:0] f_reg(input logic [4:0] r);
      return (r == 0) ? 32'h0 : rf_mem[r];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_hv <= 1'b0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_wen <= 1'b0; m_pay <= '0; m_pend <= '0;
      end else begin
         if (wb_rd != 0) m_pend[wb_rd] <= 1'b0;
         if (f_valid() && out_ready && m_wen && m_rd != 0) m_pend[m_rd] <= 1'b1;
         if (flush) m_hv <= 1'b0;
         else if (in_valid && f_ready()) begin
            m_hv <= 1'b1; m_rs1 <= in_rs1; m_rs2 <= in_rs2; m_rd <= in_rd; m_wen <= in_wen; m_pay <= in_payload;
         end else if (f_valid() && out_ready) m_hv <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("in_ready", in_ready, f_ready());
      chk("out_valid", out_valid, f_valid());
      chk("rf_rs1", rf_rs1, (in_valid && f_ready()) ? in_rs1 : m_rs1);
      chk("rf_rs2", rf_rs2, (in_valid && f_ready()) ? in_rs2 : m_rs2);
      if (f_valid()) begin
         chk("out_rs1_data", out_rs1_data, f_reg(m_rs1));
         chk("out_rs2_data", out_rs2_data, f_reg(m_rs2));
         chk("out_rd", out_rd, m_rd);
         chk("out_wen", out_wen, m_wen);
         chk("out_payload", out_payload, m_pay);
      end
      if (out_valid && out_ready) begin
         log_pay.push_back(out_payload);
         log_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic w, input logic [31:0] p);
      in_valid = 1'b1; in_rs1 = a; in_rs2 = b; in_rd = d; in_wen = w; in_payload = p;
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_rf_rs1", rf_rs1, 5'd0);
      chk("rst_payload", out_payload, 32'h0);
      chk("rst_rs1_data", out_rs1_data, 32'h0);
      step();
      rst = 1'b1;
      wb_rd = 5'd5; wb_data = 32'h1234;
      step();
      wb_rd = 5'd0; out_ready = 1'b0;
      issue(5'd5, 5'd0, 5'd1, 1'b0, 32'h101);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_rs1", out_rs1_data, 32'h1234);
      chk("t1_rs2", out_rs2_data, 32'h0);
      out_ready = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE;
      issue(5'd7, 5'd0, 5'd2, 1'b0, 32'h102);
      step();
      wb_rd = 5'd0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_bypass", out_rs1_data, 32'hCAFE);
      chk("t2_payload", out_payload, 32'h102);
      step();
      @(negedge clk);
      chk("t2_reread", out_rs1_data, 32'hCAFE);
      out_ready = 1'b1;
      issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h103);
      step();
      issue(5'd0, 5'd3, 5'd4, 1'b0, 32'h104);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t3_stall0", out_valid, 1'b0);
      step();
      @(negedge clk);
      chk("t3_stall1", out_valid, 1'b0);
      wb_rd = 5'd3; wb_data = 32'h55;
      step();
      wb_rd = 5'd0;
      @(negedge clk);
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_rs2", out_rs2_data, 32'h55);
      issue(5'd9, 5'd0, 5'd0, 1'b0, 32'hC0DE);
      step();
      out_ready = 1'b0;
      issue(5'd0, 5'd0, 5'd0, 1'b0, 32'hD00D);
      for (int i = 0; i < 4; i++) begin
         wb_rd = (i == 1) ? 5'd9 : 5'd0; wb_data = 32'hAA;
         @(negedge clk);
         chk("t4_ready", in_ready, 1'b0);
         chk("t4_payload", out_payload, 32'hC0DE);
         chk("t4_rs1", out_rs1_data, (i >= 2) ? 32'hAA : 32'h0);
         step();
      end
      wb_rd = 5'd0; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      log_pay.delete();
      log_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         issue(5'(i + 10), 5'(i + 1), 5'd0, 1'b0, 32'h500 + i);
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      chk("t5_fires", log_pay.size(), 8);
      for (int k = 0; k < log_pay.size() && k < 8; k++) begin
         chk("t5_order", log_pay[k], 32'h500 + k);
         if (k > 0) chk("t5_consec", log_cyc[k] - log_cyc[k-1], 1);
      end
      issue(5'd0, 5'd0, 5'd12, 1'b1, 32'h600);
      step();
      issue(5'd12, 5'd0, 5'd13, 1'b0, 32'h601);
      step();
      flush = 1'b1;
      issue(5'd0, 5'd0, 5'd0, 1'b0, 32'h602);
      @(negedge clk);
      chk("t6_hazard", out_valid, 1'b0);
      chk("t6_flush_ready", in_ready, 1'b0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("t6_flushed_valid", out_valid, 1'b0);
      chk("t6_flushed_ready", in_ready, 1'b1);
      issue(5'd12, 5'd0, 5'd0, 1'b0, 32'h603);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_still_pending", out_valid, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0; out_ready = 1'b0;
      issue(5'd0, 5'd0, 5'd0, 1'b0, 32'h604);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_held", out_valid, 1'b1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_ready", in_ready, 1'b1);
      chk("t6_rst_payload", out_payload, 32'h0);
      step();
      rst = 1'b1; out_ready = 1'b1;
      issue(5'd12, 5'd0, 5'd0, 1'b0, 32'h605);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_pend_cleared", out_valid, 1'b1);
      chk("t6_payload", out_payload, 32'h605);
      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage sitting directly upstream of the 2R1W register file, between decode and execute.
- Accepts decoded instructions on a valid/ready handshake and drives the register file read addresses.
- Merges the register file's 1-cycle-latency read data with a writeback bypass.
- Holds instructions behind a pending-write scoreboard, then presents resolved operands to execute on a valid/ready handshake.

Parameters:
- XLEN, 32, operand/data width.
- RADDR_W, 5, register address width (2^RADDR_W registers; x0 hardwired zero).
- PAYLOAD_W, 32, opaque decoded-instruction payload passed through unchanged.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept.
- in_rs1  in  RADDR_W  source 1 index.
- in_rs2  in  RADDR_W  source 2 index.
- in_rd  in  RADDR_W  destination index.
- in_wen  in  1  instruction writes in_rd.
- in_payload  in  PAYLOAD_W  pass-through.
- flush  in  1  discard held instruction.
- rf_rs1  out  RADDR_W  register file read address 1.
- rf_rs2  out  RADDR_W  register file read address 2.
- rf_data1  in  XLEN  register file read data 1 (registered by the register file, 1 cycle after address).
- rf_data2  in  XLEN  register file read data 2 (registered by the register file, 1 cycle after address).
- wb_rd  in  RADDR_W  writeback destination, the same signal that drives the register file write port; 0 = no write.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  operands resolved, instruction offered.
- out_ready  in  1  execute accepts.
- out_rs1_data  out  XLEN  resolved operand 1.
- out_rs2_data  out  XLEN  resolved operand 2.
- out_rd  out  RADDR_W  held destination.
- out_wen  out  1  held write enable.
- out_payload  out  PAYLOAD_W  held payload.

Behaviour:
- Reset (rst low, async):
  - Holding register cleared: hv=0, rs1/rs2/rd/wen/payload=0.
  - Scoreboard pending bitmap all 0; bypass flags 0, bypass data 0.
  - Outputs: out_valid=0, in_ready=1, out_* data=0, rf_rs1/rf_rs2=0.
- Accept: acc = in_valid && in_ready.
  - in_ready = !hv || (out_valid && out_ready); single entry, full throughput.
  - On acc, the holding register loads in_* and hv=1.
  - Else, if out_valid && out_ready (fire), hv=0. Otherwise the entry holds.
- Read address mux (combinational): rf_rs1 = acc ? in_rs1 : held rs1; likewise rf_rs2.
  - The register file therefore re-reads held addresses every cycle while stalled, so data stays current.
- Bypass:
  - The register file returns the pre-write value when a read and a write to the same index share an edge.
  - At each edge, byp1 <= (wb_rd!=0 && wb_rd==rf_rs1) and bdat1 <= wb_data; likewise byp2 for rf_rs2.
  - out_rs1_data = (held rs1==0) ? 0 : (byp1 ? bdat1 : rf_data1); same rule for operand 2.
- Scoreboard:
  - pending[2^RADDR_W] marks destinations issued to execute but not yet written back.
  - Set pending[out_rd] on fire when out_wen && out_rd!=0.
  - Clear pending[wb_rd] when wb_rd!=0.
  - Same register set and cleared on the same edge: set wins (new producer).
  - pending[0] is always 0.
- Hazard and output valid:
  - hazard = pending[held rs1] || pending[held rs2], using the registered bitmap.
  - out_valid = hv && !hazard.
  - A writeback clearing a pending source also captures its bypass on that edge, so out_valid rises the next cycle with correct data.
- Latency: accepted with no hazard -> out_valid the cycle after acceptance. Back-to-back accept/fire sustains 1 instruction/cycle.
- out_rd, out_wen, out_payload come straight from the holding register.
  - Values are stable and out_valid stays high until fire, except when flush is asserted.
- flush: at the edge, hv=0 and acc is suppressed (in_ready=0 while flush=1).
  - The scoreboard and bypass flags are unaffected; in-flight writes still retire.
- Dependent back-to-back: instruction B reads the rd of instruction A, which fired on the same edge B was accepted.
  - pending is set at that edge, so B stalls until the writeback of A, then issues with bypassed data.

Test Plan:
1. Reset then write x5=0x1234 via wb; accept rs1=5, rs2=0 -> next cycle out_valid=1, out_rs1_data=0x1234, out_rs2_data=0.
2. wb_rd=7, wb_data=0xCAFE on the same edge as accepting rs1=7 (register file returns stale 0) -> out_rs1_data=0xCAFE.
3. Fire A (rd=3, wen=1), accept B (rs2=3) -> out_valid=0 until wb_rd=3, wb_data=0x55; next cycle out_valid=1, out_rs2_data=0x55.
4. out_ready=0 for 4 cycles while wb writes x9=0xAA to held rs1=9 -> in_ready=0 throughout, out_payload stable, out_rs1_data=0xAA after the write edge.
5. Stream 8 independent instructions with out_ready=1 -> 8 fires in 8 consecutive cycles, payloads in order.
6. flush while held with hazard pending; separately assert rst mid-stall -> flush gives out_valid=0, in_ready=1 after the edge; rst clears out_valid immediately and all pending bits.
